// File: rtl/counter_pkg.sv
// Shared constants for the modulo-N up/down counter family.
// Encodes the meaning of the mode and up inputs so that the counter
// top and its step helper agree on polarity.
package counter_pkg;

    // mode input encoding
    localparam logic MODE_WRAP    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    // up input encoding
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage : counter_pkg

// File: rtl/mod_next_val.sv
// Step and wrap arithmetic for the modulo-N counter.
// Given the current count and direction it produces the value one step on
// (already wrapped into 0..MOD-1) and flags whether the count sits on the
// terminal value for that direction.
//   cnt     : current count (0..MOD-1)
//   up      : direction, DIR_UP increments, DIR_DOWN decrements
//   next    : count after one step, wrapped
//   at_term : cnt equals MOD-1 (up) or 0 (down)
module mod_next_val
    import counter_pkg::*;
#(
    parameter int W   = 4,
    parameter int MOD = 16
) (
    input  logic [W-1:0] cnt,
    input  logic         up,
    output logic [W-1:0] next,
    output logic         at_term
);

    // Arithmetic is carried one bit wider so MOD == 2**W never relies on
    // natural overflow of a W-bit add.
    localparam logic [W:0] LAST = (W+1)'(MOD - 1);

    logic [W:0] cnt_ext_s;
    logic [W:0] next_ext_s;

    // Terminal detection and wrapped next value by explicit comparison.
    always_comb begin
        cnt_ext_s  = {1'b0, cnt};
        next_ext_s = cnt_ext_s;
        if (up == DIR_UP) begin
            at_term = (cnt_ext_s == LAST);
            if (at_term) begin
                next_ext_s = {(W+1){1'b0}};
            end else begin
                next_ext_s = cnt_ext_s + {{W{1'b0}}, 1'b1};
            end
        end else begin
            at_term = (cnt_ext_s == {(W+1){1'b0}});
            if (at_term) begin
                next_ext_s = LAST;
            end else begin
                next_ext_s = cnt_ext_s - {{W{1'b0}}, 1'b1};
            end
        end
    end

    // Both branches keep next_ext_s within 0..MOD-1, so the top bit is zero.
    assign next = W'(next_ext_s);

endmodule : mod_next_val

// File: rtl/mod_updown_counter.sv
// Parametrised modulo-N up/down counter with wrap or one-shot behaviour.
// Priority on each rising edge: clr > load > en > hold.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   en       : count enable, one step per cycle
//   clr      : synchronous clear of count and flags
//   load     : synchronous load of load_val (clamped to MOD-1)
//   load_val : value for load
//   up       : direction, 1 = increment, 0 = decrement
//   mode     : 0 = wrap, 1 = one-shot (stop at terminal)
//   cnt      : registered count, always within 0..MOD-1
//   tc       : combinational terminal count, usable as next stage's en
//   wrap     : registered pulse the cycle after a wrap
//   done     : registered sticky one-shot completion flag
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int W   = 4,
    parameter int MOD = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         up,
    input  logic         mode,
    output logic [W-1:0] cnt,
    output logic         tc,
    output logic         wrap,
    output logic         done
);

    // Reject impossible parameter combinations at elaboration.
    generate
        if ((W < 1) || (MOD < 2) || (MOD > (2 ** W))) begin : g_param_check
            $fatal(1, "mod_updown_counter: need W >= 1 and 2 <= MOD <= 2**W");
        end
    endgenerate

    localparam logic [W:0] MOD_EXT  = (W+1)'(MOD);
    localparam logic [W-1:0] LAST_W = W'(MOD - 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         done_q, done_d;
    logic         wrap_q, wrap_d;
    logic [W-1:0] step_s;
    logic         at_term_s;

    mod_next_val #(
        .W   (W),
        .MOD (MOD)
    ) u_next_val (
        .cnt     (cnt_q),
        .up      (up),
        .next    (step_s),
        .at_term (at_term_s)
    );

    // Next-state selection for count and flags.
    always_comb begin
        cnt_d  = cnt_q;
        done_d = done_q;
        wrap_d = 1'b0;
        if (clr) begin
            cnt_d  = {W{1'b0}};
            done_d = 1'b0;
        end else if (load) begin
            // Compare in W+1 bits so MOD == 2**W never clamps a legal value.
            if ({1'b0, load_val} < MOD_EXT) begin
                cnt_d = load_val;
            end else begin
                cnt_d = LAST_W;
            end
            done_d = 1'b0;
        end else if (en && !done_q) begin
            if (at_term_s && (mode == MODE_ONESHOT)) begin
                done_d = 1'b1;
            end else begin
                cnt_d  = step_s;
                wrap_d = at_term_s;
            end
        end else begin
            cnt_d  = cnt_q;
            done_d = done_q;
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= {W{1'b0}};
            done_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
            wrap_q <= wrap_d;
        end
    end

    // tc is combinational so a cascaded stage steps on the same edge as
    // this stage wraps.
    assign tc   = en & at_term_s & ~done_q;
    assign cnt  = cnt_q;
    assign wrap = wrap_q;
    assign done = done_q;

endmodule : mod_updown_counter

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: MOD=10 and MOD=8 (=2**W) instances share
// stimulus and are compared every cycle with an arithmetic model; a
// two-stage MOD=10 chain is compared with a free-running decimal count.
module tb_mod_updown_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, en, clr, load, up, mode;
    logic [3:0] lv;
    logic [2:0] lv8;
    assign lv8 = lv[2:0];

    logic [3:0] cnt;
    logic       tc, wrap, done;
    logic [2:0] cnt8;
    logic       tc8, wrap8, done8;
    logic [3:0] ch1_cnt, ch2_cnt;
    logic       ch1_tc, ch1_wrap, ch1_done, ch2_tc, ch2_wrap, ch2_done;

    mod_updown_counter #(.W(4), .MOD(10)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
        .load_val(lv), .up(up), .mode(mode),
        .cnt(cnt), .tc(tc), .wrap(wrap), .done(done)
    );

    mod_updown_counter #(.W(3), .MOD(8)) d8 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
        .load_val(lv8), .up(up), .mode(mode),
        .cnt(cnt8), .tc(tc8), .wrap(wrap8), .done(done8)
    );

    mod_updown_counter #(.W(4), .MOD(10)) ch1 (
        .clk(clk), .rst_n(rst_n), .en(1'b1), .clr(1'b0), .load(1'b0),
        .load_val(4'd0), .up(1'b1), .mode(1'b0),
        .cnt(ch1_cnt), .tc(ch1_tc), .wrap(ch1_wrap), .done(ch1_done)
    );

    mod_updown_counter #(.W(4), .MOD(10)) ch2 (
        .clk(clk), .rst_n(rst_n), .en(ch1_tc), .clr(1'b0), .load(1'b0),
        .load_val(4'd0), .up(1'b1), .mode(1'b0),
        .cnt(ch2_cnt), .tc(ch2_tc), .wrap(ch2_wrap), .done(ch2_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: index 0 is the MOD=10 instance, 1 the MOD=8 one.
    int mods [2] = '{10, 8};
    int m_cnt [2];
    bit m_done [2];
    bit m_wrap [2];
    int ch_k;

    // Model update on each edge from the inputs sampled at that edge.
    always @(posedge clk or negedge rst_n) begin : model
        int lvk, term, nxt;
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_cnt[k]  = 0;
                m_done[k] = 1'b0;
                m_wrap[k] = 1'b0;
            end
            ch_k = 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                lvk  = (k == 0) ? int'(lv) : int'(lv8);
                term = up ? mods[k] - 1 : 0;
                nxt  = (m_cnt[k] + (up ? 1 : mods[k] - 1)) % mods[k];
                m_wrap[k] = 1'b0;
                if (clr) begin
                    m_cnt[k]  = 0;
                    m_done[k] = 1'b0;
                end else if (load) begin
                    m_cnt[k]  = (lvk < mods[k]) ? lvk : mods[k] - 1;
                    m_done[k] = 1'b0;
                end else if (en && !m_done[k]) begin
                    if ((m_cnt[k] == term) && mode) begin
                        m_done[k] = 1'b1;
                    end else begin
                        m_wrap[k] = (m_cnt[k] == term);
                        m_cnt[k]  = nxt;
                    end
                end
            end
            ch_k = ch_k + 1;
        end
    end

    // Compare every output against the model, away from the active edge.
    always @(negedge clk) begin
        chk("cnt",  cnt,  m_cnt[0]);
        chk("done", done, int'(m_done[0]));
        chk("wrap", wrap, int'(m_wrap[0]));
        chk("tc",   tc,   int'(en && (m_cnt[0] == (up ? 9 : 0)) && !m_done[0]));
        chk("cnt8",  cnt8,  m_cnt[1]);
        chk("done8", done8, int'(m_done[1]));
        chk("wrap8", wrap8, int'(m_wrap[1]));
        chk("tc8",   tc8,   int'(en && (m_cnt[1] == (up ? 7 : 0)) && !m_done[1]));
        chk("ch1_cnt",  ch1_cnt,  ch_k % 10);
        chk("ch2_cnt",  ch2_cnt,  (ch_k / 10) % 10);
        chk("ch1_tc",   ch1_tc,   int'((ch_k % 10) == 9));
        chk("ch2_tc",   ch2_tc,   int'((ch_k % 100) == 99));
        chk("ch1_wrap", ch1_wrap, int'((ch_k > 0) && ((ch_k % 10) == 0)));
        chk("ch2_wrap", ch2_wrap, int'((ch_k > 0) && ((ch_k % 100) == 0)));
        chk("ch_done",  {ch1_done, ch2_done}, 0);
    end

    task automatic cyc(input logic e, input logic c, input logic l,
                       input logic [3:0] v, input logic u, input logic m);
        en = e; clr = c; load = l; lv = v; up = u; mode = m;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0;
        lv = 4'd0; up = 1'b1; mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_cnt", cnt, 0);
        chk("reset_flags", {done, wrap}, 0);

        // Up count, wrap mode, 12 cycles.
        for (int i = 1; i <= 12; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
            if (i == 9)  chk("up_at9", cnt, 9);
            if (i == 10) begin chk("up_wrap_cnt", cnt, 0); chk("up_wrap_pulse", wrap, 1); end
            if (i == 12) begin chk("up_cnt12", cnt, 2); chk("up_wrap_gone", wrap, 0); end
        end

        // Down count from 0.
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("down_cnt9", cnt, 9);
        chk("down_wrap", wrap, 1);
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("down_cnt8", cnt, 8);
        chk("down_wrap_once", wrap, 0);

        // One-shot up to 9, then frozen, then released by load.
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
        for (int i = 1; i <= 15; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
            if (i == 9)  begin chk("os_cnt9", cnt, 9); chk("os_not_done", done, 0); end
            if (i == 10) begin chk("os_done", done, 1); chk("os_hold", cnt, 9); end
            if (i == 15) begin chk("os_frozen", cnt, 9); chk("os_sticky", done, 1); end
        end
        cyc(1'b1, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1);
        chk("os_load_cnt", cnt, 3);
        chk("os_load_done", done, 0);

        // clr beats load beats en; out-of-range load clamps.
        cyc(1'b1, 1'b1, 1'b1, 4'd12, 1'b1, 1'b0);
        chk("clr_priority", cnt, 0);
        cyc(1'b0, 1'b0, 1'b1, 4'd12, 1'b1, 1'b0);
        chk("load_clamp", cnt, 9);
        chk("load_mod8", cnt8, 4);

        // Full-range modulus (2**W) wraps 7 -> 0.
        cyc(1'b0, 1'b0, 1'b1, 4'd7, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        chk("mod8_wrap_cnt", cnt8, 0);
        chk("mod8_wrap_pulse", wrap8, 1);

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            cyc(logic'($urandom_range(0, 7) != 0), logic'($urandom_range(0, 31) == 0),
                logic'($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)),
                logic'($urandom_range(0, 1)), logic'($urandom_range(0, 3) == 0));
        end

        // Asynchronous reset between edges.
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        chk("pre_reset_cnt", cnt, 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_cnt", cnt, 0);
        chk("async_rst_flags", {done, wrap}, 0);
        @(posedge clk);
        #1;
        chk("rst_held", cnt, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        chk("post_rst_cnt", cnt, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mod_updown_counter
